// File: rtl/spi_master_cfg.sv
// rtl/spi_master_cfg.sv - configurable SPI master, DATA_W-bit full-duplex, runtime divider and mode
// Ports: clk/reset; tx_data/tx_valid/tx_ready request handshake; rx_data/rx_valid completion pulse;
//        busy; ss_sel/cpol/cpha/lsb_first/clk_div latched at accept; sclk/mosi/miso/ss_n SPI pins.
module spi_master_cfg #(
  parameter int DATA_W = 8,
  parameter int NUM_SS = 4,
  parameter int SEL_W  = 2,
  parameter int DIV_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  input  logic [SEL_W-1:0]  ss_sel,
  input  logic              cpol,
  input  logic              cpha,
  input  logic              lsb_first,
  input  logic [DIV_W-1:0]  clk_div,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_SS-1:0] ss_n
);

  localparam int EDGE_W = $clog2(2 * DATA_W + 1);
  localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * DATA_W);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_XFER, S_HOLD, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q, cnt_d, div_q, div_d;
  logic [EDGE_W-1:0] edge_q, edge_d, edge_k;
  logic              cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [DATA_W-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, rx_data_q, rx_data_d;
  logic              sclk_q, sclk_d, mosi_q, mosi_d, rx_valid_q, rx_valid_d;
  logic [NUM_SS-1:0] ss_n_q, ss_n_d;
  logic              tick, sample_edge;

  function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
    return lsb ? {1'b0, w[DATA_W-1:1]} : {w[DATA_W-2:0], 1'b0};
  endfunction

  // Received bits enter from the end opposite to the one transmitted first, so the
  // first bit on the wire lands at the same word position for tx and rx.
  function automatic logic [DATA_W-1:0] shift_in(input logic [DATA_W-1:0] w, input logic lsb,
                                                 input logic b);
    return lsb ? {b, w[DATA_W-1:1]} : {w[DATA_W-2:0], b};
  endfunction

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    edge_d     = edge_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    lsb_d      = lsb_q;
    tx_sh_d    = tx_sh_q;
    rx_sh_d    = rx_sh_q;
    rx_data_d  = rx_data_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    rx_valid_d = 1'b0;

    // Counter runs 0..div_q, so H = div_q+1 never needs a value wider than DIV_W.
    tick        = (cnt_q == div_q);
    edge_k      = edge_q + EDGE_W'(1);
    // Odd edges are leading; cpha=0 samples on leading, cpha=1 on trailing.
    sample_edge = (edge_k[0] != cpha_q);

    if (state_q != S_IDLE) cnt_d = tick ? '0 : cnt_q + DIV_W'(1);

    unique case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        sclk_d = cpol_q;
        if (tx_valid) begin
          state_d = S_SETUP;
          div_d   = clk_div;
          cpol_d  = cpol;
          cpha_d  = cpha;
          lsb_d   = lsb_first;
          edge_d  = '0;
          rx_sh_d = '0;
          sclk_d  = cpol;
          // Out-of-range selects leave every line deasserted.
          for (int i = 0; i < NUM_SS; i++) ss_n_d[i] = (int'(ss_sel) != i);
          if (!cpha) begin
            mosi_d  = head_bit(tx_data, lsb_first);
            tx_sh_d = shift_out(tx_data, lsb_first);
          end else begin
            tx_sh_d = tx_data;
          end
        end
      end
      S_SETUP, S_XFER: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_k;
          if (sample_edge) begin
            rx_sh_d = shift_in(rx_sh_q, lsb_q, miso);
          end else if (edge_k != LAST_EDGE) begin
            mosi_d  = head_bit(tx_sh_q, lsb_q);
            tx_sh_d = shift_out(tx_sh_q, lsb_q);
          end
          state_d = (edge_k == LAST_EDGE) ? S_HOLD : S_XFER;
        end
      end
      S_HOLD: begin
        if (tick) begin
          ss_n_d     = '1;
          rx_data_d  = rx_sh_q;
          rx_valid_d = 1'b1;
          state_d    = S_GAP;
        end
      end
      S_GAP: begin
        if (tick) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      edge_q     <= '0;
      cpol_q     <= 1'b0;
      cpha_q     <= 1'b0;
      lsb_q      <= 1'b0;
      tx_sh_q    <= '0;
      rx_sh_q    <= '0;
      rx_data_q  <= '0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      ss_n_q     <= '1;
      rx_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_q      <= div_d;
      edge_q     <= edge_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      lsb_q      <= lsb_d;
      tx_sh_q    <= tx_sh_d;
      rx_sh_q    <= rx_sh_d;
      rx_data_q  <= rx_data_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      rx_valid_q <= rx_valid_d;
    end
  end

  assign tx_ready = (state_q == S_IDLE);
  assign busy     = ~tx_ready;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign ss_n     = ss_n_q;

endmodule

// File: tb/tb_spi_master_cfg.sv
// tb/tb_spi_master_cfg.sv - self-checking bench for spi_master_cfg
module tb_spi_master_cfg;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready;
  logic [2:0] ss_sel;
  logic       cpol, cpha, lsb_first;
  logic [7:0] clk_div;
  logic [7:0] rx_data;
  logic       rx_valid, busy, sclk, mosi, miso;
  logic [3:0] ss_n;

  int total = 0;
  int bad   = 0;

  spi_master_cfg #(.DATA_W(8), .NUM_SS(4), .SEL_W(3), .DIV_W(8)) dut (
    .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ss_sel(ss_sel), .cpol(cpol), .cpha(cpha), .lsb_first(lsb_first), .clk_div(clk_div),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .sclk(sclk), .mosi(mosi),
    .miso(miso), .ss_n(ss_n)
  );

  always #5 clk = ~clk;

  // Slave model: a plain SPI slave working from wire-level edges.
  logic       loop_mode = 1'b1;
  logic       m_cpol = 1'b0, m_cpha = 1'b0, m_lsb = 1'b0;
  logic [7:0] slave_tx = 8'h00, slave_rx = 8'h00;
  logic       slave_miso = 1'b0;
  logic       ss_low, ss_low_prev = 1'b0, sclk_prev = 1'b0;
  int         s_edge = 0, s_drv = 0, s_in = 0;

  assign ss_low = (ss_n != 4'hF);
  assign miso   = loop_mode ? mosi : slave_miso;

  function automatic int bit_pos(input int i);
    return m_lsb ? i : 7 - i;
  endfunction

  always @(sclk or ss_low) begin
    if (ss_low && !ss_low_prev) begin
      s_edge = 0; s_drv = 0; s_in = 0; slave_rx = 8'h00;
      if (!m_cpha) begin slave_miso = slave_tx[bit_pos(0)]; s_drv = 1; end
    end else if (ss_low && sclk !== sclk_prev && !(s_edge == 0 && sclk == m_cpol)) begin
      s_edge++;
      if (((s_edge % 2) == 1) != m_cpha) begin
        if (s_in < 8) slave_rx[bit_pos(s_in)] = mosi;
        s_in++;
      end else if (s_drv < 8) begin
        slave_miso = slave_tx[bit_pos(s_drv)];
        s_drv++;
      end
    end
    if (!ss_low) s_edge = 0;
    ss_low_prev = ss_low;
    sclk_prev   = sclk;
  end

  // Per-transfer observations
  int         m_low, m_tog, m_bad_int, m_rxv, m_gap, m_hold;
  logic [3:0] m_mask;
  logic [7:0] m_rx;
  logic       m_busy1, m_first_mosi, m_sclk_start, m_sclk_end, m_timeout;

  task automatic run_xfer(input logic [7:0] tx, input logic [2:0] sel, input logic pol,
                          input logic pha, input logic lsb, input logic [7:0] div);
    int h, last_tog, rxv_c;
    logic prev_s, seen, done;
    h = int'(div) + 1;
    m_cpol = pol; m_cpha = pha; m_lsb = lsb;
    @(negedge clk);
    tx_data = tx; ss_sel = sel; cpol = pol; cpha = pha; lsb_first = lsb; clk_div = div;
    tx_valid = 1'b1;
    @(negedge clk);
    // Scramble every request input right after accept; none may affect this transfer.
    tx_valid = 1'b0; tx_data = ~tx; cpol = ~pol; cpha = ~pha; lsb_first = ~lsb;
    clk_div = 8'($urandom); ss_sel = 3'($urandom);
    m_low = 0; m_mask = 4'h0; m_tog = 0; m_bad_int = 0; m_rxv = 0; m_rx = 8'h00;
    m_gap = -1; m_hold = -1;
    m_busy1 = busy; m_first_mosi = mosi; m_sclk_start = sclk;
    prev_s = sclk; last_tog = 1; seen = 1'b0; done = 1'b0; rxv_c = 0;
    for (int c = 1; c < 20000 && !done; c++) begin
      if (c > 1) @(negedge clk);
      if (ss_n != 4'hF) m_low++;
      m_mask = m_mask | ~ss_n;
      if (sclk !== prev_s) begin
        m_tog++;
        if (c - last_tog != h) m_bad_int++;
        last_tog = c; prev_s = sclk;
      end
      if (rx_valid) begin
        m_rxv++; m_rx = rx_data; seen = 1'b1; rxv_c = c; m_hold = c - last_tog;
      end
      if (seen && tx_ready) begin m_gap = c - rxv_c; done = 1'b1; end
    end
    m_timeout = !done;
    m_sclk_end = sclk;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rst_tx_ready got=%0h exp=1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0h exp=0", busy); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL rst_sclk got=%0h exp=0", sclk); end
    total++; if (mosi !== 1'b0) begin bad++; $display("FAIL rst_mosi got=%0h exp=0", mosi); end
    total++; if (ss_n !== 4'hF) begin bad++; $display("FAIL rst_ss_n got=%0h exp=f", ss_n); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL rst_rx_data got=%0h exp=0", rx_data); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL rst_rx_valid got=%0h exp=0", rx_valid); end
    reset = 1'b0;
    @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL rel_tx_ready got=%0h exp=1", tx_ready); end
  endtask

  task automatic test_mode0_loopback;
    loop_mode = 1'b1;
    run_xfer(8'hA5, 3'd0, 1'b0, 1'b0, 1'b0, 8'd0);
    total++; if (m_timeout !== 1'b0) begin bad++; $display("FAIL m0_timeout got=%0h exp=0", m_timeout); end
    total++; if (m_busy1 !== 1'b1) begin bad++; $display("FAIL m0_busy got=%0h exp=1", m_busy1); end
    total++; if (m_rx !== 8'hA5) begin bad++; $display("FAIL m0_rx got=%0h exp=a5", m_rx); end
    total++; if (m_rxv !== 1) begin bad++; $display("FAIL m0_rxv_pulses got=%0d exp=1", m_rxv); end
    total++; if (m_low !== 17) begin bad++; $display("FAIL m0_ss_low got=%0d exp=17", m_low); end
    total++; if (m_mask !== 4'b0001) begin bad++; $display("FAIL m0_ss_mask got=%0h exp=1", m_mask); end
    total++; if (m_tog !== 16) begin bad++; $display("FAIL m0_edges got=%0d exp=16", m_tog); end
    total++; if (m_bad_int !== 0) begin bad++; $display("FAIL m0_half_period got=%0d exp=0", m_bad_int); end
    total++; if (m_hold !== 1) begin bad++; $display("FAIL m0_hold got=%0d exp=1", m_hold); end
    total++; if (m_gap !== 1) begin bad++; $display("FAIL m0_gap got=%0d exp=1", m_gap); end
    total++; if (m_first_mosi !== 1'b1) begin bad++; $display("FAIL m0_first_mosi got=%0h exp=1", m_first_mosi); end
    total++; if (m_sclk_end !== 1'b0) begin bad++; $display("FAIL m0_sclk_idle got=%0h exp=0", m_sclk_end); end
  endtask

  task automatic test_modes;
    loop_mode = 1'b0;
    slave_tx  = 8'h3C;
    for (int m = 1; m < 4; m++) begin
      run_xfer(8'hC3, 3'd0, m[1], m[0], 1'b0, 8'd1);
      total++; if (m_timeout !== 1'b0) begin bad++; $display("FAIL mode%0d_timeout got=%0h exp=0", m, m_timeout); end
      total++; if (m_rx !== 8'h3C) begin bad++; $display("FAIL mode%0d_rx got=%0h exp=3c", m, m_rx); end
      total++; if (slave_rx !== 8'hC3) begin bad++; $display("FAIL mode%0d_slave_rx got=%0h exp=c3", m, slave_rx); end
      total++; if (m_sclk_start !== m[1]) begin bad++; $display("FAIL mode%0d_sclk_start got=%0h exp=%0h", m, m_sclk_start, m[1]); end
      total++; if (m_sclk_end !== m[1]) begin bad++; $display("FAIL mode%0d_sclk_end got=%0h exp=%0h", m, m_sclk_end, m[1]); end
      total++; if (m_tog !== 16) begin bad++; $display("FAIL mode%0d_edges got=%0d exp=16", m, m_tog); end
    end
    loop_mode = 1'b1;
  endtask

  task automatic test_lsb_div;
    loop_mode = 1'b1;
    run_xfer(8'h01, 3'd1, 1'b0, 1'b0, 1'b1, 8'd3);
    total++; if (m_first_mosi !== 1'b1) begin bad++; $display("FAIL lsb_first_mosi got=%0h exp=1", m_first_mosi); end
    total++; if (m_bad_int !== 0) begin bad++; $display("FAIL div3_half_period got=%0d exp=0", m_bad_int); end
    total++; if (m_tog !== 16) begin bad++; $display("FAIL div3_edges got=%0d exp=16", m_tog); end
    total++; if (m_low !== 68) begin bad++; $display("FAIL div3_ss_low got=%0d exp=68", m_low); end
    total++; if (m_rx !== 8'h01) begin bad++; $display("FAIL lsb_rx got=%0h exp=1", m_rx); end
    total++; if (m_mask !== 4'b0010) begin bad++; $display("FAIL lsb_ss_mask got=%0h exp=2", m_mask); end
    run_xfer(8'h01, 3'd1, 1'b0, 1'b0, 1'b0, 8'd3);
    total++; if (m_first_mosi !== 1'b0) begin bad++; $display("FAIL msb_first_mosi got=%0h exp=0", m_first_mosi); end
  endtask

  task automatic test_ss_sel;
    loop_mode = 1'b1;
    run_xfer(8'h4E, 3'd2, 1'b0, 1'b0, 1'b0, 8'd0);
    total++; if (m_mask !== 4'b0100) begin bad++; $display("FAIL sel2_mask got=%0h exp=4", m_mask); end
    total++; if (m_rx !== 8'h4E) begin bad++; $display("FAIL sel2_rx got=%0h exp=4e", m_rx); end
    run_xfer(8'hB1, 3'd5, 1'b0, 1'b0, 1'b0, 8'd0);
    total++; if (m_mask !== 4'b0000) begin bad++; $display("FAIL sel5_mask got=%0h exp=0", m_mask); end
    total++; if (m_low !== 0) begin bad++; $display("FAIL sel5_ss_low got=%0d exp=0", m_low); end
    total++; if (m_rxv !== 1) begin bad++; $display("FAIL sel5_rxv_pulses got=%0d exp=1", m_rxv); end
    total++; if (m_rx !== 8'hB1) begin bad++; $display("FAIL sel5_rx got=%0h exp=b1", m_rx); end
  endtask

  task automatic test_max_div;
    loop_mode = 1'b1;
    run_xfer(8'h5A, 3'd3, 1'b0, 1'b1, 1'b0, 8'd255);
    total++; if (m_low !== 17 * 256) begin bad++; $display("FAIL maxdiv_ss_low got=%0d exp=%0d", m_low, 17 * 256); end
    total++; if (m_bad_int !== 0) begin bad++; $display("FAIL maxdiv_half_period got=%0d exp=0", m_bad_int); end
    total++; if (m_rx !== 8'h5A) begin bad++; $display("FAIL maxdiv_rx got=%0h exp=5a", m_rx); end
    total++; if (m_gap !== 256) begin bad++; $display("FAIL maxdiv_gap got=%0d exp=256", m_gap); end
  endtask

  task automatic test_random;
    logic [7:0] tx, div;
    logic [2:0] sel;
    logic       pol, pha, lsb;
    logic [3:0] exp_mask;
    loop_mode = 1'b0;
    for (int n = 0; n < 8; n++) begin
      slave_tx = 8'($urandom);
      tx  = 8'($urandom);
      pol = 1'($urandom); pha = 1'($urandom); lsb = 1'($urandom);
      div = 8'($urandom_range(0, 4));
      sel = 3'($urandom_range(0, 3));
      exp_mask = 4'(1 << sel);
      run_xfer(tx, sel, pol, pha, lsb, div);
      total++; if (m_rx !== slave_tx) begin bad++; $display("FAIL rnd%0d_rx got=%0h exp=%0h", n, m_rx, slave_tx); end
      total++; if (slave_rx !== tx) begin bad++; $display("FAIL rnd%0d_slave_rx got=%0h exp=%0h", n, slave_rx, tx); end
      total++; if (m_low !== 17 * (int'(div) + 1)) begin bad++; $display("FAIL rnd%0d_ss_low got=%0d exp=%0d", n, m_low, 17 * (int'(div) + 1)); end
      total++; if (m_mask !== exp_mask) begin bad++; $display("FAIL rnd%0d_mask got=%0h exp=%0h", n, m_mask, exp_mask); end
    end
    loop_mode = 1'b1;
  endtask

  task automatic test_back_to_back;
    int hc, pulses, phase;
    logic [7:0] rx1, rx2;
    loop_mode = 1'b1;
    m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
    @(negedge clk);
    tx_data = 8'h96; ss_sel = 3'd0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; clk_div = 8'd1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h69;
    hc = 0; pulses = 0; phase = 0; rx1 = 8'h00; rx2 = 8'h00;
    for (int c = 0; c < 2000 && phase < 3; c++) begin
      @(negedge clk);
      if (rx_valid) begin
        pulses++;
        if (pulses == 1) rx1 = rx_data; else rx2 = rx_data;
      end
      case (phase)
        0: if (pulses == 1) begin phase = 1; hc = 1; end
        1: if (ss_n == 4'hF) hc++; else begin phase = 2; tx_valid = 1'b0; end
        2: if (pulses == 2) phase = 3;
        default: ;
      endcase
    end
    tx_valid = 1'b0;
    for (int c = 0; c < 100 && !tx_ready; c++) @(negedge clk);
    total++; if (phase !== 3) begin bad++; $display("FAIL b2b_timeout got=%0d exp=3", phase); end
    total++; if (hc !== 3) begin bad++; $display("FAIL b2b_ss_high got=%0d exp=3", hc); end
    total++; if (pulses !== 2) begin bad++; $display("FAIL b2b_pulses got=%0d exp=2", pulses); end
    total++; if (rx1 !== 8'h96) begin bad++; $display("FAIL b2b_rx1 got=%0h exp=96", rx1); end
    total++; if (rx2 !== 8'h69) begin bad++; $display("FAIL b2b_rx2 got=%0h exp=69", rx2); end
  endtask

  task automatic test_reset_mid;
    int tog;
    logic prev_s;
    loop_mode = 1'b1;
    @(negedge clk);
    tx_data = 8'hE7; ss_sel = 3'd1; cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b0; clk_div = 8'd1;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    tog = 0; prev_s = sclk;
    for (int c = 0; c < 500 && tog < 7; c++) begin
      @(negedge clk);
      if (sclk !== prev_s) begin tog++; prev_s = sclk; end
    end
    total++; if (tog !== 7) begin bad++; $display("FAIL mid_edges got=%0d exp=7", tog); end
    #1 reset = 1'b1;
    #1;
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL mid_tx_ready got=%0h exp=1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%0h exp=0", busy); end
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL mid_sclk got=%0h exp=0", sclk); end
    total++; if (mosi !== 1'b0) begin bad++; $display("FAIL mid_mosi got=%0h exp=0", mosi); end
    total++; if (ss_n !== 4'hF) begin bad++; $display("FAIL mid_ss_n got=%0h exp=f", ss_n); end
    total++; if (rx_data !== 8'h00) begin bad++; $display("FAIL mid_rx_data got=%0h exp=0", rx_data); end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (sclk !== 1'b0) begin bad++; $display("FAIL post_rst_sclk got=%0h exp=0", sclk); end
    run_xfer(8'h2D, 3'd0, 1'b0, 1'b0, 1'b0, 8'd2);
    total++; if (m_rx !== 8'h2D) begin bad++; $display("FAIL post_rst_rx got=%0h exp=2d", m_rx); end
    total++; if (m_low !== 51) begin bad++; $display("FAIL post_rst_ss_low got=%0d exp=51", m_low); end
  endtask

  initial begin
    reset = 1'b1;
    tx_data = 8'h00; tx_valid = 1'b0; ss_sel = 3'd0; cpol = 1'b0; cpha = 1'b0;
    lsb_first = 1'b0; clk_div = 8'd0;
    test_reset();
    test_mode0_loopback();
    test_modes();
    test_lsb_div();
    test_ss_sel();
    test_max_div();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
